// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, word type, GF(2^8) helpers and the key-schedule FSM states.
// Everything here is combinational or type-only; it adds no latency and has no backpressure.
package aes_pkg;

  localparam int AES_NK         = 4;
  localparam int AES_MAX_ROUNDS = 10;

  typedef logic [31:0] aes_word_t;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1; also used by MixColumns.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
// Purely combinational, zero latency, no backpressure.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] inv;
  logic [7:0] pw;

  // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
  end

  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: S-box applied independently to each byte of a 32-bit word.
// Combinational, zero latency, no backpressure.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t w,
  output aes_word_t s
);

  for (genvar i = 0; i < AES_NK; i++) begin : g_byte
    aes_sbox u_sbox (
      .a (w[8*i +: 8]),
      .s (s[8*i +: 8])
    );
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: key 0 one cycle after start, then one key per accepted cycle.
// key_ready low freezes every register, so round_key/round_idx hold until accepted.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > AES_MAX_ROUNDS) begin : g_bad_rounds
    $error("aes_key_schedule: NUM_ROUNDS must be in 1..10");
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_e  state;
  logic [7:0] rcon;

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot, sub, temp;
  aes_word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = round_key;
  assign rot = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .w (rot),
    .s (sub)
  );

  assign temp = sub ^ {rcon, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KS_IDLE;
      rcon      <= 8'h01;
      key_valid <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        KS_IDLE: begin
          if (start) begin
            state     <= KS_RUN;
            round_key <= key_in;
            round_idx <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        KS_RUN: begin
          // start is deliberately ignored here, including on the final acceptance.
          if (key_valid && key_ready) begin
            if (round_idx == LAST_IDX) begin
              state     <= KS_IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              round_key <= {n0, n1, n2, n3};
              round_idx <= round_idx + 4'd1;
              rcon      <= xtime(rcon);
            end
          end
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a FIPS-197 style full-array key expansion model.
module tb_aes_key_schedule;

  localparam int NR = 10;

  logic         clk;
  logic         rst_n;
  logic         start, start3;
  logic [127:0] key_in, key_in3;
  logic         key_ready, key_ready3;
  logic         key_valid, key_valid3;
  logic [127:0] round_key, round_key3;
  logic [3:0]   round_idx, round_idx3;
  logic         busy, busy3;
  logic         done, done3;

  aes_key_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .key_ready(key_ready),
    .key_valid(key_valid), .round_key(round_key), .round_idx(round_idx),
    .busy(busy), .done(done)
  );

  aes_key_schedule #(.NUM_ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .key_in(key_in3), .key_ready(key_ready3),
    .key_valid(key_valid3), .round_key(round_key3), .round_idx(round_idx3),
    .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_k [0:10];
  logic [127:0] obs [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box by exhaustive inverse search plus bitwise affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int r;
      int b;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(x, y) == 1) inv = y;
      r = inv;
      b = inv;
      for (int k = 0; k < 4; k++) begin
        b = ((b << 1) | (b >> 7)) & 'hff;
        r = r ^ b;
      end
      sb[x] = 8'(r ^ 'h63);
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc = 1;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ (32'(rc) << 24);
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one schedule from load; mode 0 = ready held high, 1 = random ready.
  // poke drives start during RUN; abort_at >= 0 asserts reset on that index.
  task automatic run_ks(input logic [127:0] k, input int mode, input bit poke, input int abort_at);
    int  ie = 0;
    int  cyc = 0;
    bit  fin = 0;
    bit  rdy;
    expand(k);
    key_in = k;
    start = 1'b1;
    key_ready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    while (!fin && cyc < 200) begin
      chk("key_valid", 128'(key_valid), 128'(1));
      chk("busy", 128'(busy), 128'(1));
      chk("round_idx", 128'(round_idx), 128'(ie));
      chk("round_key", round_key, exp_k[ie]);
      obs[ie] = round_key;
      if (ie == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst key_valid", 128'(key_valid), 128'(0));
        chk("rst round_key", round_key, 128'(0));
        chk("rst round_idx", 128'(round_idx), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst done", 128'(done), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst idle", 128'(key_valid), 128'(0));
        fin = 1;
      end else begin
        rdy = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 2) != 0));
        key_ready = rdy;
        if (poke) start = (ie == NR) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        if (rdy) begin
          if (ie == NR) begin
            fin = 1;
            chk("done pulse", 128'(done), 128'(1));
            chk("final key_valid", 128'(key_valid), 128'(0));
            chk("final busy", 128'(busy), 128'(0));
            chk("final idx held", 128'(round_idx), 128'(NR));
            chk("final key held", round_key, exp_k[NR]);
            key_ready = 1'b1;
            @(posedge clk); #1;
            chk("done one cycle", 128'(done), 128'(0));
            chk("no reload", 128'(key_valid), 128'(0));
          end else begin
            ie++;
          end
        end
      end
    end
    if (!fin) chk("schedule timeout", 128'(0), 128'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; key_in = '0; key_ready = 1'b0;
    start3 = 1'b0; key_in3 = '0; key_ready3 = 1'b0;
    build_sbox();
    @(posedge clk); #1;
    chk("reset key_valid", 128'(key_valid), 128'(0));
    chk("reset round_key", round_key, 128'(0));
    chk("reset round_idx", 128'(round_idx), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // key_ready alone in IDLE must not start anything.
    key_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle ready no effect", 128'(key_valid), 128'(0));

    run_ks(FIPS_KEY, 0, 0, -1);
    chk("fips idx1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips idx10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_ks(FIPS_KEY, 1, 0, -1);
    chk("bp fips idx10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_ks(128'h0, 0, 0, -1);
    chk("zero idx1", obs[1], 128'h62636363626363636263636362636363);
    chk("zero idx10", obs[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int n = 0; n < 3; n++)
      run_ks({$urandom, $urandom, $urandom, $urandom}, 1, 1, -1);
    // Restart two cycles after done, with a fresh key.
    run_ks({$urandom, $urandom, $urandom, $urandom}, 0, 0, -1);

    run_ks(FIPS_KEY, 0, 0, 5);
    run_ks(FIPS_KEY, 1, 0, -1);

    // Shortened schedule: NUM_ROUNDS = 3.
    expand(FIPS_KEY);
    key_in3 = FIPS_KEY;
    start3 = 1'b1;
    key_ready3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int r = 0; r <= 3; r++) begin
      chk("nr3 idx", 128'(round_idx3), 128'(r));
      chk("nr3 key", round_key3, exp_k[r]);
      chk("nr3 valid", 128'(key_valid3), 128'(1));
      if (r == 3) chk("nr3 idx3 literal", round_key3, 128'h3d80477d4716fe3e1e237e446d7a883b);
      @(posedge clk); #1;
    end
    chk("nr3 done", 128'(done3), 128'(1));
    chk("nr3 valid drop", 128'(key_valid3), 128'(0));
    chk("nr3 busy drop", 128'(busy3), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
